// File: rtl/mux2to1_input.sv
// Operand-source selector for the adder datapath: picks functional or pin
// operands under one select and registers them so the adder sees flop-driven inputs.
module mux2to1_input #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pin_a,
  input  logic [N-1:0] pin_b,
  input  logic         pin_cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sel,
  output logic [N-1:0] sel_a,
  output logic [N-1:0] sel_b,
  output logic         sel_cin
);

  logic [N-1:0] sel_a_d, sel_a_q;
  logic [N-1:0] sel_b_d, sel_b_q;
  logic         sel_cin_d, sel_cin_q;

  // Single select steers all three lanes together; mixed sourcing is not possible.
  always_comb begin
    sel_a_d   = a;
    sel_b_d   = b;
    sel_cin_d = cin;
    if (sel) begin
      sel_a_d   = pin_a;
      sel_b_d   = pin_b;
      sel_cin_d = pin_cin;
    end else begin
      sel_a_d   = a;
      sel_b_d   = b;
      sel_cin_d = cin;
    end
  end

  // Output flops; reset clears them immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q   <= {N{1'b0}};
      sel_b_q   <= {N{1'b0}};
      sel_cin_q <= 1'b0;
    end else begin
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      sel_cin_q <= sel_cin_d;
    end
  end

  assign sel_a   = sel_a_q;
  assign sel_b   = sel_b_q;
  assign sel_cin = sel_cin_q;

endmodule

// File: tb/tb_mux2to1_input.sv
// Directed and random checks of mux2to1_input at N=16, N=1 and N=32.
module tb_mux2to1_input;

  logic clk;
  logic rst_n;

  // N = 16 instance (directed tests)
  logic [15:0] pin_a, pin_b, a, b, sel_a, sel_b;
  logic        pin_cin, cin, sel, sel_cin;

  // N = 1 instance
  logic r1_pa, r1_pb, r1_pc, r1_a, r1_b, r1_c, r1_sel, r1_oa, r1_ob, r1_oc;
  logic e1_a, e1_b, e1_c;

  // N = 32 instance
  logic [31:0] r32_pa, r32_pb, r32_a, r32_b, r32_oa, r32_ob, e32_a, e32_b;
  logic        r32_pc, r32_c, r32_sel, r32_oc, e32_c;

  int checks = 0;
  int failures = 0;

  mux2to1_input #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .pin_a(pin_a), .pin_b(pin_b), .pin_cin(pin_cin),
    .a(a), .b(b), .cin(cin), .sel(sel),
    .sel_a(sel_a), .sel_b(sel_b), .sel_cin(sel_cin)
  );

  mux2to1_input #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pin_a(r1_pa), .pin_b(r1_pb), .pin_cin(r1_pc),
    .a(r1_a), .b(r1_b), .cin(r1_c), .sel(r1_sel),
    .sel_a(r1_oa), .sel_b(r1_ob), .sel_cin(r1_oc)
  );

  mux2to1_input #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .pin_a(r32_pa), .pin_b(r32_pb), .pin_cin(r32_pc),
    .a(r32_a), .b(r32_b), .cin(r32_c), .sel(r32_sel),
    .sel_a(r32_oa), .sel_b(r32_ob), .sel_cin(r32_oc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] ea, input logic [15:0] eb,
                       input logic ec);
    chk({name, ".a"},   64'(sel_a),   64'(ea));
    chk({name, ".b"},   64'(sel_b),   64'(eb));
    chk({name, ".cin"}, 64'(sel_cin), 64'(ec));
  endtask

  task automatic drive16(input logic s, input logic [15:0] fa, input logic [15:0] fb,
                         input logic fc, input logic [15:0] pa, input logic [15:0] pb,
                         input logic pc);
    sel = s; a = fa; b = fb; cin = fc; pin_a = pa; pin_b = pb; pin_cin = pc;
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] pa, pb;
    logic        pcin;
    logic [15:0] ea, eb;
    logic        ecin;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // lane independence sequence sel 0,1,0, then extra patterns
    vecs[0] = '{1'b0, 16'h1234, 16'hABCD, 1'b0, 16'h5A5A, 16'h0F0F, 1'b1, 16'h1234, 16'hABCD, 1'b0};
    vecs[1] = '{1'b1, 16'h1234, 16'hABCD, 1'b0, 16'h5A5A, 16'h0F0F, 1'b1, 16'h5A5A, 16'h0F0F, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 16'hABCD, 1'b0, 16'h5A5A, 16'h0F0F, 1'b1, 16'h1234, 16'hABCD, 1'b0};
    vecs[3] = '{1'b1, 16'h7FFF, 16'hFFFE, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 16'h0001, 1'b0};
    vecs[4] = '{1'b0, 16'h8001, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h8001, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 16'hC3C3, 16'h3C3C, 1'b0, 16'hAAAA, 16'h5555, 1'b1, 16'hAAAA, 16'h5555, 1'b1};

    rst_n = 1'b0;
    drive16(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0);
    {r1_pa, r1_pb, r1_pc, r1_a, r1_b, r1_c, r1_sel} = 7'b0;
    {r32_pa, r32_pb, r32_a, r32_b} = 128'd0;
    {r32_pc, r32_c, r32_sel} = 3'b0;
    #2;
    chk16("reset_state", 16'h0000, 16'h0000, 1'b0);
    chk("reset_state.n1", 64'({r1_oa, r1_ob, r1_oc}), 64'd0);
    chk("reset_state.n32", 64'({r32_oa, r32_ob}), 64'd0);

    // functional select
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk16("func_sel", 16'hFFFF, 16'hFFFF, 1'b1);

    // pin select: no change until the next edge
    @(negedge clk); sel = 1'b1;
    #1;
    chk16("pin_sel_hold", 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    chk16("pin_sel", 16'h0000, 16'h0000, 1'b0);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive16(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].pa, vecs[i].pb, vecs[i].pcin);
      @(posedge clk); #1;
      chk16($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ecin);
    end

    // asynchronous reset between edges with all-ones inputs
    @(negedge clk);
    drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    chk16("ones_loaded", 16'hFFFF, 16'hFFFF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk16("async_clear", 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk16($sformatf("reset_hold%0d", k), 16'h0000, 16'h0000, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk16("first_capture", 16'hFFFF, 16'hFFFF, 1'b1);

    // reset pulse of half a cycle while streaming pin operands
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive16(1'b1, 16'h0BAD + 16'(c), 16'h0FAD + 16'(c), 1'(c % 2),
              16'h1000 + 16'(c), 16'h2000 + 16'(3 * c), 1'((c + 1) % 2));
      if (c == 3) begin
        #1;
        chk16("midstream_pulse", 16'h0000, 16'h0000, 1'b0);
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
      chk16($sformatf("midstream%0d", c), 16'h1000 + 16'(c), 16'h2000 + 16'(3 * c),
            1'((c + 1) % 2));
      if (c == 2) begin
        #1 rst_n = 1'b0;
        #1;
        chk16("midstream_clear", 16'h0000, 16'h0000, 1'b0);
      end
    end

    // random sweep for N = 1 and N = 32 against a reference mux
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      {r1_pa, r1_pb, r1_pc, r1_a, r1_b, r1_c, r1_sel} = 7'($urandom_range(127, 0));
      r32_pa = $urandom; r32_pb = $urandom; r32_a = $urandom; r32_b = $urandom;
      {r32_pc, r32_c, r32_sel} = 3'($urandom_range(7, 0));
      e1_a  = r1_sel ? r1_pa : r1_a;
      e1_b  = r1_sel ? r1_pb : r1_b;
      e1_c  = r1_sel ? r1_pc : r1_c;
      e32_a = r32_sel ? r32_pa : r32_a;
      e32_b = r32_sel ? r32_pb : r32_b;
      e32_c = r32_sel ? r32_pc : r32_c;
      @(posedge clk); #1;
      chk("rand_n1", 64'({r1_oa, r1_ob, r1_oc}), 64'({e1_a, e1_b, e1_c}));
      chk("rand_n32", {r32_oa, r32_ob}, {e32_a, e32_b});
      chk("rand_n32.cin", 64'(r32_oc), 64'(e32_c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2to1_input.md
# mux2to1_input

Operand-source selector in front of the N-bit adder datapath. It routes either the functional operands (`a`, `b`, `cin`) or the external pin operands (`pin_a`, `pin_b`, `pin_cin`) to the adder inputs, under a single select. The selected operands are registered so the adder sees stable, glitch-free inputs. This lets test or bring-up logic drive the adder directly from pins.

## Interface
Parameters:
- `N`, default 16: operand width in bits; legal range 1..64.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `pin_a`  in  N  external-pin operand A.
- `pin_b`  in  N  external-pin operand B.
- `pin_cin`  in  1  external-pin carry-in.
- `a`  in  N  functional operand A.
- `b`  in  N  functional operand B.
- `cin`  in  1  functional carry-in.
- `sel`  in  1  source select: 0 = functional (`a`/`b`/`cin`), 1 = pins (`pin_a`/`pin_b`/`pin_cin`).
- `sel_a`  out  N  selected operand A, registered.
- `sel_b`  out  N  selected operand B, registered.
- `sel_cin`  out  1  selected carry-in, registered.

## Operation
- Next-state equations, evaluated per bit:
  - `sel_a_d = sel ? pin_a : a`
  - `sel_b_d = sel ? pin_b : b`
  - `sel_cin_d = sel ? pin_cin : cin`
- All three outputs use the same `sel`. Mixed selection (A from pins, B functional) is not supported.
- No arithmetic is performed. Widths pass through unchanged, with no extension or truncation.
- Every output is driven directly by a flop. There is no combinational path from any input to any output.
- No internal state beyond the 2N+1 output flops. There is no FSM.

## Timing
- Reset:
  - While `rst_n` = 0, `sel_a` = 0, `sel_b` = 0 and `sel_cin` = 0.
  - Outputs clear immediately on the falling edge of `rst_n`, independent of `clk`.
  - Reset asserted mid-operation discards the current contents immediately.
- First capture is on the first rising `clk` edge at which `rst_n` = 1.
- Latency:
  - Exactly one cycle.
  - Inputs and `sel` sampled at rising edge k appear on the outputs after edge k and hold until edge k+1.
- `sel` changes take effect at the next rising edge only. There are no intermediate or mixed values.
- Inputs may change every cycle. Each output is updated every cycle and has no enable.
- Throughput is one new operand set per cycle.

## Test plan
- Reset:
  - Drive all inputs to all-ones with `sel` = 1, and assert `rst_n` = 0 between clock edges.
  - Required: outputs = 0 without waiting for a `clk` edge, and they stay 0 across 3 clock edges while `rst_n` is held low.
- Functional select:
  - `pin_a` = `pin_b` = 0x0000, `pin_cin` = 0, `a` = `b` = 0xFFFF, `cin` = 1, `sel` = 0.
  - Required: after one edge, `sel_a` = 0xFFFF, `sel_b` = 0xFFFF, `sel_cin` = 1.
- Pin select:
  - Same operands as the functional-select case, switch `sel` to 1.
  - Required: the outputs stay 0xFFFF/0xFFFF/1 until the next edge, then read 0x0000/0x0000/0.
- Independence of lanes:
  - `a` = 0x1234, `b` = 0xABCD, `cin` = 0, `pin_a` = 0x5A5A, `pin_b` = 0x0F0F, `pin_cin` = 1.
  - Toggle `sel` 0,1,0 on consecutive cycles.
  - Required: outputs follow the sequence (0x1234, 0xABCD, 0), then (0x5A5A, 0x0F0F, 1), then (0x1234, 0xABCD, 0), each one cycle after its `sel` value.
- Reset mid-stream:
  - While streaming a new operand set every cycle with `sel` = 1, pulse `rst_n` low for half a cycle.
  - Required: outputs read 0 during the pulse and on the first edge after deassertion capture the then-current pin values.
- Parameter sweep:
  - Run `N` = 1 and `N` = 32 with random operands and random `sel` for 1000 cycles.
  - Required: every output matches the one-cycle-delayed reference mux.
